bus_arbiter_mux: RTL and testbench
==================================

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, number of stalled access cycles (1..255) before forced bus release.
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mN_req_  in  1  (N=0..3) bus request from master N, active-low.
REQ-006 mN_addr  in  32  (N=0..3) master N address.
REQ-007 mN_as_  in  1  (N=0..3) master N address strobe, active-low.
REQ-008 mN_rw  in  1  (N=0..3) master N direction; 1=read, 0=write.
REQ-009 mN_wr_data  in  32  (N=0..3) master N write data.
REQ-010 mN_grnt_  out  1  (N=0..3) bus grant to master N, active-low, registered.
REQ-011 s_addr  out  32  shared slave address; drives the address decoder downstream.
REQ-012 s_as_  out  1  shared address strobe, active-low.
REQ-013 s_rw  out  1  shared direction.
REQ-014 s_wr_data  out  32  shared write data.
REQ-015 s_rdy_  in  1  selected-slave ready, active-low.
REQ-016 bus_timeout  out  1  one-cycle pulse on forced release, active-high, registered.

Function
REQ-017 FSM SHALL have two states: IDLE (no owner) and GRANT (exactly one owner).
REQ-018 At most one mN_grnt_ SHALL be low in any cycle; in IDLE, all SHALL be high.
REQ-019 IDLE: if any mN_req_ is low at edge k, state SHALL be GRANT with the winner's grant low from edge k+1 (latency 1).
REQ-020 Arbitration SHALL be round-robin: search order starts at last_owner+1 mod 4 and wraps; last_owner resets to 3, so master 0 has priority after reset.
REQ-021 GRANT: owner SHALL hold the bus while its mN_req_ is low; requests from other masters SHALL NOT preempt.
REQ-022 GRANT: owner mN_req_ high at edge k -> grant high and IDLE from k+1; last_owner updated to the releasing owner.
REQ-023 Every ownership change SHALL pass through at least one IDLE cycle (turnaround); no master-to-master grant handoff in a single cycle.
REQ-024 Mux (combinational on state/owner): in GRANT, s_addr, s_as_, s_rw, s_wr_data SHALL equal the owner's signals; in IDLE, s_addr=0, s_as_=1, s_rw=1, s_wr_data=0.
REQ-025 Stall counter (8 bits): in GRANT it increments each cycle with owner as_=0 and s_rdy_=1; it clears on s_rdy_=0, as_=1, entry to IDLE, or reset.
REQ-026 Counter reaching TIMEOUT_CYCLES-1 with stall still present at the edge SHALL cause the following: bus_timeout=1 for exactly the next cycle; grant withdrawn; IDLE; last_owner=owner; counter cleared.
REQ-027 A timed-out master still requesting SHALL be re-arbitrated normally; round-robin order places it last.
REQ-028 The counter SHALL NOT wrap; TIMEOUT_CYCLES outside 1..255 is illegal.
REQ-029 An owner releasing req_ in the same cycle as the timeout SHALL produce bus_timeout=1; the resulting state is IDLE in both cases.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, all mN_grnt_=1, last_owner=3, counter=0, bus_timeout=0, overriding any in-flight access.
REQ-031 Mux outputs SHALL take IDLE values in the cycle after reset is sampled.
REQ-032 Requests present during reset SHALL be ignored; arbitration starts at the first edge with reset=0, and the grant appears one cycle later.

Verification
REQ-033 Reset released, m2_req_=0 only -> m2_grnt_=0 one cycle later; s_addr follows m2_addr (e.g. 0x4000_0010).
REQ-034 All four request continuously; each releases after 3 cycles -> grant order 0,1,2,3,0, with one IDLE cycle between owners.
REQ-035 m1 owns; m0 and m3 request -> m1 keeps the bus; after m1 releases, m3 is granted before m0.
REQ-036 m0 owns with as_=0 and s_rdy_=1 held, TIMEOUT_CYCLES=4 -> bus_timeout pulses 1 cycle after the 4th stalled cycle; m0_grnt_=1; s_as_=1.
REQ-037 Mid-access reset (m3 granted, as_=0) -> next cycle all grants=1, s_as_=1, s_addr=0; counter=0.
REQ-038 Single-grant assertion checker active in all scenarios: never more than one mN_grnt_ low.

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// Four-master round-robin bus arbiter with an owner-selected slave mux.
// A stall watchdog forces the bus free after TIMEOUT_CYCLES stalled access cycles.
module bus_arbiter_mux #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req_,
    input  logic [31:0] m0_addr,
    input  logic        m0_as_,
    input  logic        m0_rw,
    input  logic [31:0] m0_wr_data,
    input  logic        m1_req_,
    input  logic [31:0] m1_addr,
    input  logic        m1_as_,
    input  logic        m1_rw,
    input  logic [31:0] m1_wr_data,
    input  logic        m2_req_,
    input  logic [31:0] m2_addr,
    input  logic        m2_as_,
    input  logic        m2_rw,
    input  logic [31:0] m2_wr_data,
    input  logic        m3_req_,
    input  logic [31:0] m3_addr,
    input  logic        m3_as_,
    input  logic        m3_rw,
    input  logic [31:0] m3_wr_data,
    output logic        m0_grnt_,
    output logic        m1_grnt_,
    output logic        m2_grnt_,
    output logic        m3_grnt_,
    output logic [31:0] s_addr,
    output logic        s_as_,
    output logic        s_rw,
    output logic [31:0] s_wr_data,
    input  logic        s_rdy_,
    output logic        bus_timeout
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    logic [3:0]       req_n, as_n, rw;
    logic [3:0][31:0] addr, wr_data;

    assign req_n   = {m3_req_, m2_req_, m1_req_, m0_req_};
    assign as_n    = {m3_as_, m2_as_, m1_as_, m0_as_};
    assign rw      = {m3_rw, m2_rw, m1_rw, m0_rw};
    assign addr    = {m3_addr, m2_addr, m1_addr, m0_addr};
    assign wr_data = {m3_wr_data, m2_wr_data, m1_wr_data, m0_wr_data};

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt, last_owner, last_nxt;
    logic [7:0] stall_cnt, cnt_nxt;
    logic [3:0] grnt_n, grnt_nxt;
    logic       to_nxt, found, stall;
    logic [1:0] win, cand;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last_owner;
        cnt_nxt   = 8'd0;
        to_nxt    = 1'b0;
        found     = 1'b0;
        win       = last_owner;
        cand      = last_owner;
        stall     = 1'b0;

        // Search starts one past the last owner; i=4 wraps back to it.
        for (int i = 1; i <= 4; i++) begin
            cand = last_owner + 2'(i);
            if (!found && !req_n[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = GRANT;
                    owner_nxt = win;
                end
            end
            GRANT: begin
                stall = !as_n[owner] && s_rdy_;
                // Timeout wins over a simultaneous release so the pulse is never lost.
                if (stall && stall_cnt == TMO_LAST) begin
                    to_nxt    = 1'b1;
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else if (req_n[owner]) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                end else if (stall) begin
                    cnt_nxt = stall_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        grnt_nxt = 4'hF;
        if (state_nxt == GRANT) grnt_nxt[owner_nxt] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 2'd0;
            last_owner  <= 2'd3;
            stall_cnt   <= 8'd0;
            grnt_n      <= 4'hF;
            bus_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last_owner  <= last_nxt;
            stall_cnt   <= cnt_nxt;
            grnt_n      <= grnt_nxt;
            bus_timeout <= to_nxt;
        end
    end

    assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_n;

    always_comb begin
        s_addr    = 32'd0;
        s_as_     = 1'b1;
        s_rw      = 1'b1;
        s_wr_data = 32'd0;
        if (state == GRANT) begin
            s_addr    = addr[owner];
            s_as_     = as_n[owner];
            s_rw      = rw[owner];
            s_wr_data = wr_data[owner];
        end
    end
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: directed vector table, corner sequences, and random
// traffic checked against a cycle-level ownership model.
module tb_bus_arbiter_mux;
    localparam int T = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req, as, rw;
    logic [3:0][31:0] addr, wd;
    logic             rdy;
    logic [3:0]       grnt;
    logic [31:0]      s_addr, s_wr_data;
    logic             s_as_, s_rw, bus_timeout;

    int tests = 0;
    int fails = 0;
    bit started = 0;

    always #5 clk = ~clk;

    bus_arbiter_mux #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .m0_req_(req[0]), .m0_addr(addr[0]), .m0_as_(as[0]), .m0_rw(rw[0]), .m0_wr_data(wd[0]),
        .m1_req_(req[1]), .m1_addr(addr[1]), .m1_as_(as[1]), .m1_rw(rw[1]), .m1_wr_data(wd[1]),
        .m2_req_(req[2]), .m2_addr(addr[2]), .m2_as_(as[2]), .m2_rw(rw[2]), .m2_wr_data(wd[2]),
        .m3_req_(req[3]), .m3_addr(addr[3]), .m3_as_(as[3]), .m3_rw(rw[3]), .m3_wr_data(wd[3]),
        .m0_grnt_(grnt[0]), .m1_grnt_(grnt[1]), .m2_grnt_(grnt[2]), .m3_grnt_(grnt[3]),
        .s_addr(s_addr), .s_as_(s_as_), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .s_rdy_(rdy), .bus_timeout(bus_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 = bus free), last owner, stalled-cycle tally.
    int m_own = -1, m_last = 3, m_stall = 0;
    bit m_to = 0;
    int m_c;
    bit m_found, m_st;

    always @(posedge clk) begin
        if (reset) begin
            m_own = -1; m_last = 3; m_stall = 0; m_to = 0;
        end else if (m_own < 0) begin
            m_to = 0; m_stall = 0; m_found = 0;
            for (int i = 1; i <= 4; i++) begin
                m_c = (m_last + i) % 4;
                if (!m_found && !req[m_c]) begin
                    m_found = 1; m_own = m_c;
                end
            end
        end else begin
            m_st = !as[m_own] && rdy;
            if (m_st && m_stall + 1 == T) begin
                m_to = 1; m_last = m_own; m_own = -1; m_stall = 0;
            end else if (req[m_own]) begin
                m_to = 0; m_last = m_own; m_own = -1; m_stall = 0;
            end else begin
                m_to = 0; m_stall = m_st ? m_stall + 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("one_hot_grant", {31'd0, $onehot0(~grnt)}, 32'd1);
            chk("m_grnt", {28'd0, grnt}, (m_own < 0) ? 32'hF : {28'd0, ~(4'b0001 << m_own)});
            chk("m_timeout", {31'd0, bus_timeout}, {31'd0, m_to});
            chk("m_s_addr", s_addr, (m_own < 0) ? 32'd0 : addr[m_own]);
            chk("m_s_as", {31'd0, s_as_}, (m_own < 0) ? 32'd1 : {31'd0, as[m_own]});
            chk("m_s_rw", {31'd0, s_rw}, (m_own < 0) ? 32'd1 : {31'd0, rw[m_own]});
            chk("m_s_wr_data", s_wr_data, (m_own < 0) ? 32'd0 : wd[m_own]);
        end
    end

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grnt;
    } vec_t;

    vec_t vecs[26];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 4'hF; as = 4'hF; rdy = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 4'hF; as = 4'hF; rw = 4'hF; rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr[i] = 32'h1000_0000 * (i + 1) + 32'h10;
            wd[i]   = 32'hA5A5_0000 + 32'(i);
        end

        // Requests held during reset must be ignored.
        req = 4'b1011;
        addr[2] = 32'h4000_0010;
        step();
        started = 1;
        step();
        chk("reset_grnt", {28'd0, grnt}, 32'hF);
        chk("reset_timeout", {31'd0, bus_timeout}, 32'd0);
        chk("reset_s_as", {31'd0, s_as_}, 32'd1);
        reset = 1'b0;
        step();
        chk("m2_grant", {28'd0, grnt}, 32'hB);
        chk("m2_s_addr", s_addr, 32'h4000_0010);

        // Round-robin rotation, then no preemption of m1 by m0/m3.
        vecs = '{
            '{4'h0, 4'hE}, '{4'h0, 4'hE}, '{4'h0, 4'hE}, '{4'h1, 4'hF},
            '{4'h0, 4'hD}, '{4'h0, 4'hD}, '{4'h0, 4'hD}, '{4'h2, 4'hF},
            '{4'h0, 4'hB}, '{4'h0, 4'hB}, '{4'h0, 4'hB}, '{4'h4, 4'hF},
            '{4'h0, 4'h7}, '{4'h0, 4'h7}, '{4'h0, 4'h7}, '{4'h8, 4'hF},
            '{4'h0, 4'hE}, '{4'h1, 4'hF}, '{4'hD, 4'hD}, '{4'h4, 4'hD},
            '{4'h4, 4'hD}, '{4'h6, 4'hF}, '{4'h6, 4'h7}, '{4'h8, 4'hF},
            '{4'hE, 4'hE}, '{4'hF, 4'hF}
        };
        do_reset();
        for (int v = 0; v < 26; v++) begin
            req = vecs[v].req;
            step();
            chk($sformatf("vec%0d_grnt", v), {28'd0, grnt}, {28'd0, vecs[v].exp_grnt});
            chk($sformatf("vec%0d_timeout", v), {31'd0, bus_timeout}, 32'd0);
        end

        // Stall watchdog on m0, then timeout coinciding with release.
        do_reset();
        req = 4'hE; as = 4'hE; rdy = 1'b1;
        step();
        chk("to_grant", {28'd0, grnt}, 32'hE);
        for (int k = 0; k < T - 1; k++) begin
            step();
            chk("to_pre_timeout", {31'd0, bus_timeout}, 32'd0);
            chk("to_pre_grnt", {28'd0, grnt}, 32'hE);
        end
        step();
        chk("to_pulse", {31'd0, bus_timeout}, 32'd1);
        chk("to_grnt_rel", {28'd0, grnt}, 32'hF);
        chk("to_s_as", {31'd0, s_as_}, 32'd1);
        step();
        chk("to_pulse_end", {31'd0, bus_timeout}, 32'd0);
        chk("to_regrant", {28'd0, grnt}, 32'hE);
        for (int k = 0; k < T - 1; k++) step();
        req = 4'hF;
        step();
        chk("to_release_pulse", {31'd0, bus_timeout}, 32'd1);
        chk("to_release_grnt", {28'd0, grnt}, 32'hF);

        // Reset in the middle of an m3 access.
        do_reset();
        req = 4'h7; as = 4'h7; rdy = 1'b0;
        step();
        chk("m3_grant", {28'd0, grnt}, 32'h7);
        chk("m3_s_as", {31'd0, s_as_}, 32'd0);
        reset = 1'b1;
        step();
        chk("midrst_grnt", {28'd0, grnt}, 32'hF);
        chk("midrst_s_as", {31'd0, s_as_}, 32'd1);
        chk("midrst_s_addr", s_addr, 32'd0);
        reset = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
                as[i]   = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
                rw[i]   = 1'($urandom);
                addr[i] = $urandom;
                wd[i]   = $urandom;
            end
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
